// File: rtl/pl_adc_stream_if.sv
// Valid/ready beat stream with frame-end marker, from the ADC capture block to the PL FIFO/DMA path.
interface pl_adc_stream_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] o_Data;
    logic             o_Valid;
    logic             o_Last;
    logic             i_Ready;

    modport master (output o_Data, output o_Valid, output o_Last, input i_Ready);
    modport slave  (input o_Data, input o_Valid, input o_Last, output i_Ready);
endinterface

// File: rtl/pl_adc_stream.sv
// Multichannel CMOS ADC capture: test patterns, integer decimation and framed valid/ready output
// with a sticky overflow flag for beats dropped under backpressure.
module pl_adc_stream #(
    parameter int                DATA_W    = 12,
    parameter int                OUT_W     = 16,
    parameter int                NUM_CH    = 2,
    parameter logic [DATA_W-1:0] CONST_PAT = 12'h929
) (
    input  logic                     i_CMOS_Clk,
    input  logic                     i_Reset,
    input  logic [NUM_CH*DATA_W-1:0] i_CMOS_Data,
    input  logic                     i_ADC_Work,
    input  logic [31:0]              i_Count,
    input  logic [7:0]               i_Decim,
    input  logic [1:0]               i_Mode,
    pl_adc_stream_if.master          o_Stream,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Overflow
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   r_State;
    state_t                   w_NextState;
    logic [NUM_CH*DATA_W-1:0] r_Sample;
    logic [NUM_CH*OUT_W-1:0]  r_Data;
    logic [NUM_CH*OUT_W-1:0]  w_Beat;
    logic [DATA_W-1:0]        w_Val;
    logic                     r_Valid;
    logic                     r_Last;
    logic                     r_Overflow;
    logic                     r_Abort;
    logic [31:0]              r_Count;
    logic [31:0]              r_Beat;
    logic [7:0]               r_Decim;
    logic [7:0]               r_DecCnt;
    logic [7:0]               w_DecMax;
    logic [1:0]               r_Mode;
    logic                     w_Accept;
    logic                     w_Empty;
    logic                     w_Start;
    logic                     w_Due;
    logic                     w_IsLast;

    // Empty also covers a slot being handed off this cycle, so back-to-back beats never stall.
    assign w_Accept = r_Valid & o_Stream.i_Ready;
    assign w_Empty  = ~r_Valid | w_Accept;
    assign w_Start  = (r_State == S_IDLE) & i_ADC_Work;
    assign w_Due    = (r_State == S_RUN) & i_ADC_Work & (r_DecCnt == 8'd0);
    assign w_IsLast = (r_Beat == r_Count - 32'd1);
    assign w_DecMax = (r_Decim <= 8'd1) ? 8'd0 : r_Decim - 8'd1;

    assign o_Stream.o_Data  = r_Data;
    assign o_Stream.o_Valid = r_Valid;
    assign o_Stream.o_Last  = r_Last;
    assign o_Overflow       = r_Overflow;

    always_comb begin
        w_Beat = '0;
        w_Val  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (r_Mode)
                2'd1:    w_Val = DATA_W'(r_Beat + 32'(k));
                2'd2:    w_Val = CONST_PAT;
                default: w_Val = r_Sample[k*DATA_W +: DATA_W];
            endcase
            w_Beat[k*OUT_W +: OUT_W] = OUT_W'(w_Val) << (OUT_W - DATA_W);
        end
    end

    always_ff @(posedge i_CMOS_Clk) begin
        if (i_Reset) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            S_IDLE: begin
                if (i_ADC_Work) begin
                    w_NextState = (i_Count == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!i_ADC_Work || (w_Due && w_IsLast)) begin
                    w_NextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_Empty) begin
                    w_NextState = r_Abort ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (!i_ADC_Work) begin
                    w_NextState = S_IDLE;
                end
            end
            default: w_NextState = S_IDLE;
        endcase
    end

    always_comb begin
        o_Busy = (r_State == S_RUN) || (r_State == S_DRAIN);
        o_Done = (r_State == S_DONE);
    end

    // A due beat that finds the slot still held is dropped; if it was the final one, the held beat closes the frame.
    always_ff @(posedge i_CMOS_Clk) begin
        if (i_Reset) begin
            r_Sample   <= '0;
            r_Data     <= '0;
            r_Valid    <= 1'b0;
            r_Last     <= 1'b0;
            r_Overflow <= 1'b0;
            r_Abort    <= 1'b0;
            r_Count    <= '0;
            r_Beat     <= '0;
            r_Decim    <= '0;
            r_DecCnt   <= '0;
            r_Mode     <= '0;
        end else begin
            r_Sample <= i_CMOS_Data;
            if (w_Start) begin
                r_Count    <= i_Count;
                r_Decim    <= i_Decim;
                r_Mode     <= i_Mode;
                r_Beat     <= '0;
                r_DecCnt   <= '0;
                r_Overflow <= 1'b0;
                r_Abort    <= 1'b0;
            end
            if (r_State == S_RUN) begin
                if (!i_ADC_Work) begin
                    r_Abort <= 1'b1;
                end else begin
                    r_DecCnt <= (r_DecCnt >= w_DecMax) ? 8'd0 : r_DecCnt + 8'd1;
                end
            end
            if (w_Due) begin
                r_Beat <= r_Beat + 32'd1;
                if (w_Empty) begin
                    r_Data  <= w_Beat;
                    r_Valid <= 1'b1;
                    r_Last  <= w_IsLast;
                end else begin
                    r_Overflow <= 1'b1;
                    if (w_IsLast) begin
                        r_Last <= 1'b1;
                    end
                end
            end else if (w_Accept) begin
                r_Valid <= 1'b0;
                r_Last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pl_adc_stream.sv
// Bench for pl_adc_stream: directed and randomized frames compared cycle by cycle against a
// frame-level model built from beat schedule, slot occupancy and drop rules.
module tb_pl_adc_stream;
    localparam int DATA_W = 12;
    localparam int OUT_W  = 16;
    localparam int NUM_CH = 2;
    localparam int PW     = NUM_CH * DATA_W;
    localparam int MAXC   = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] cmosData;
    logic          adcWork;
    logic [31:0]   count;
    logic [7:0]    decim;
    logic [1:0]    mode;
    logic          busy;
    logic          done;
    logic          overflow;

    int passCnt  = 0;
    int totalCnt = 0;
    int failCnt  = 0;

    logic [PW-1:0] pins[MAXC];
    bit            rdy[MAXC];
    bit            eV[MAXC];
    bit            eL[MAXC];
    bit            eBusy[MAXC];
    bit            eDone[MAXC];
    bit            eOvf[MAXC];
    int            eN[MAXC];
    bit            prevOvf = 1'b0;
    int            curMode = 0;
    int            curD    = 1;

    pl_adc_stream_if #(.WIDTH(NUM_CH*OUT_W)) streamIf();

    pl_adc_stream #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .CONST_PAT(12'h929)
    ) dut (
        .i_CMOS_Clk (clk),
        .i_Reset    (reset),
        .i_CMOS_Data(cmosData),
        .i_ADC_Work (adcWork),
        .i_Count    (count),
        .i_Decim    (decim),
        .i_Mode     (mode),
        .o_Stream   (streamIf),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] expv);
        totalCnt++;
        assert (obs === expv) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // Expected beat n: ramp is (n + ch) mod 2^DATA_W, real data is the sample on the pins at cycle n*D.
    function automatic logic [63:0] expData(input int n);
        logic [NUM_CH*OUT_W-1:0] w;
        logic [PW-1:0]           p;
        logic [DATA_W-1:0]       v;
        w = '0;
        p = pins[n * curD];
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (curMode)
                1:       v = DATA_W'((n + ch) % (1 << DATA_W));
                2:       v = 12'h929;
                default: v = p[ch*DATA_W +: DATA_W];
            endcase
            w[ch*OUT_W +: OUT_W] = {v, {(OUT_W-DATA_W){1'b0}}};
        end
        return 64'(w);
    endfunction

    // Request seen during cycle 0; beat n is issued at edge 2+n*D into a single holding slot.
    task automatic buildModel(input int fCnt, input int abortAt, input int nCyc);
        int nNext   = 0;
        int drainAt = -1;
        int endAt   = -1;
        bit aborted = 1'b0;
        bit acc;
        bit due;
        eV[0] = 0; eN[0] = 0; eL[0] = 0; eBusy[0] = 0; eDone[0] = 0; eOvf[0] = prevOvf;
        for (int k = 1; k < nCyc; k++) begin
            eV[k] = eV[k-1]; eN[k] = eN[k-1]; eL[k] = eL[k-1];
            eOvf[k] = (k == 1) ? 1'b0 : eOvf[k-1];
            if (fCnt == 0) begin
                eBusy[k] = 0;
                eDone[k] = 1;
                continue;
            end
            acc = eV[k-1] && rdy[k-1];
            if (endAt < 0 && drainAt >= 0 && k - 1 >= drainAt && (!eV[k-1] || rdy[k-1])) endAt = k;
            due = (drainAt < 0) && (k >= 2) && ((k - 2) % curD == 0) && !(abortAt >= 0 && k > abortAt);
            if (due) begin
                if (!eV[k-1] || acc) begin
                    eV[k] = 1; eN[k] = nNext; eL[k] = (nNext == fCnt - 1);
                end else begin
                    eOvf[k] = 1;
                    if (nNext == fCnt - 1) eL[k] = 1;
                end
                if (nNext == fCnt - 1) drainAt = k;
                nNext++;
            end else if (acc) begin
                eV[k] = 0;
            end
            if (drainAt < 0 && abortAt >= 0 && k == abortAt + 1) begin
                drainAt = k;
                aborted = 1;
            end
            eBusy[k] = (endAt < 0);
            eDone[k] = (endAt >= 0) && !aborted;
        end
    endtask

    task automatic checkOutput(input int k);
        check("valid", k, 64'(streamIf.o_Valid), 64'(eV[k]));
        check("busy", k, 64'(busy), 64'(eBusy[k]));
        check("done", k, 64'(done), 64'(eDone[k]));
        check("overflow", k, 64'(overflow), 64'(eOvf[k]));
        if (eV[k]) begin
            check("data", k, 64'(streamIf.o_Data), expData(eN[k]));
            check("last", k, 64'(streamIf.o_Last), 64'(eL[k]));
        end
    endtask

    // Entered just after a rising edge with the block idle; ends the same way after releasing the request.
    task automatic applyStimulus(input int fMode, input int fCnt, input int fDec, input int abortAt, input int nCyc);
        curMode = (fMode == 3) ? 0 : fMode;
        curD    = (fDec <= 1) ? 1 : fDec;
        buildModel(fCnt, abortAt, nCyc);
        for (int k = 0; k < nCyc; k++) begin
            adcWork          = !(abortAt >= 0 && k >= abortAt);
            cmosData         = pins[k];
            streamIf.i_Ready = rdy[k];
            if (k == 0) begin
                count = 32'(fCnt); decim = 8'(fDec); mode = 2'(fMode);
            end else begin
                count = $urandom; decim = 8'($urandom); mode = 2'($urandom);
            end
            @(negedge clk);
            checkOutput(k);
            @(posedge clk); #1;
        end
        adcWork          = 1'b0;
        streamIf.i_Ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("doneClear", nCyc + 1, 64'(done), 64'(0));
        check("busyIdle", nCyc + 1, 64'(busy), 64'(0));
        check("validIdle", nCyc + 1, 64'(streamIf.o_Valid), 64'(0));
        check("ovfHold", nCyc + 1, 64'(overflow), 64'(eOvf[nCyc-1]));
        prevOvf = eOvf[nCyc-1];
        @(posedge clk); #1;
    endtask

    task automatic setPattern(input int lowFrom, input int lowLen, input int randPct);
        for (int k = 0; k < MAXC; k++) begin
            pins[k] = PW'($urandom);
            rdy[k]  = !(k >= lowFrom && k < lowFrom + lowLen);
            if (randPct > 0 && k < 30) rdy[k] = ($urandom_range(0, 99) >= randPct);
        end
    endtask

    task automatic checkAllZero(input int tag);
        check("rstValid", tag, 64'(streamIf.o_Valid), 64'(0));
        check("rstLast", tag, 64'(streamIf.o_Last), 64'(0));
        check("rstData", tag, 64'(streamIf.o_Data), 64'(0));
        check("rstBusy", tag, 64'(busy), 64'(0));
        check("rstDone", tag, 64'(done), 64'(0));
        check("rstOvf", tag, 64'(overflow), 64'(0));
    endtask

    initial begin
        reset = 1'b1; adcWork = 1'b0; cmosData = '0; count = '0; decim = '0; mode = '0;
        streamIf.i_Ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkAllZero(0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] ramp, 5 beats back to back");
        setPattern(-10, 0, 0);
        applyStimulus(1, 5, 1, -1, 20);

        $display("[TB] constant pattern, decimation 4");
        setPattern(-10, 0, 0);
        applyStimulus(2, 3, 4, -1, 24);

        $display("[TB] ramp with backpressure over beats 1-2");
        setPattern(2, 3, 0);
        applyStimulus(1, 6, 1, -1, 24);

        $display("[TB] backpressure across the final beat");
        setPattern(5, 4, 0);
        applyStimulus(1, 4, 1, -1, 24);

        $display("[TB] dropped final beat closes frame on held beat");
        setPattern(4, 4, 0);
        applyStimulus(0, 4, 1, -1, 24);

        $display("[TB] abort after 2 of 10 beats");
        setPattern(3, 3, 0);
        applyStimulus(1, 10, 1, 3, 16);

        $display("[TB] restart after abort");
        setPattern(-10, 0, 0);
        applyStimulus(1, 3, 0, -1, 12);

        $display("[TB] zero-length frame");
        setPattern(-10, 0, 0);
        applyStimulus(1, 0, 1, -1, 6);

        for (int i = 0; i < 4; i++) begin
            $display("[TB] random frame %0d", i);
            setPattern(-10, 0, 25);
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(1, 8)),
                          int'($urandom_range(0, 3)), -1, 50);
        end

        $display("[TB] reset in the middle of a frame");
        adcWork = 1'b1; count = 32'd20; decim = 8'd1; mode = 2'd1; streamIf.i_Ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("midValid", 4, 64'(streamIf.o_Valid), 64'(1));
        check("midOvf", 4, 64'(overflow), 64'(1));
        check("midBusy", 4, 64'(busy), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkAllZero(5);
        reset = 1'b0; adcWork = 1'b0; streamIf.i_Ready = 1'b1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/pl_adc_stream.md
Name: pl_adc_stream

Overview:
- Parametrised successor to the single-channel PL ADC capture block.
- Captures NUM_CH parallel CMOS ADC channels on the ADC clock and frames a programmable number of beats per work request.
- Supports real-data, ramp and constant test-pattern modes, plus integer decimation.
- Drives a valid/ready stream with TLAST-style framing into the downstream PL FIFO/DMA path, with a sticky overflow flag when backpressure drops beats.

Parameters:
- DATA_W, 12, ADC sample width per channel.
- OUT_W, 16, output word width per channel; must be >= DATA_W.
- NUM_CH, 2, number of parallel ADC channels (1..8).
- CONST_PAT, 12'h929, value used in constant pattern mode, DATA_W bits.

Ports:
- i_CMOS_Clk, in, 1, ADC clock; all logic runs on its rising edge.
- i_Reset, in, 1, synchronous, active-high reset.
- i_CMOS_Data, in, NUM_CH*DATA_W, raw ADC samples; channel k occupies bits [k*DATA_W +: DATA_W].
- i_ADC_Work, in, 1, level-sensitive frame request.
- i_Count, in, 32, beats per frame; latched at frame start.
- i_Decim, in, 8, decimation factor D; 0 and 1 both mean no decimation; latched at frame start.
- i_Mode, in, 2, source select: 0 = ADC data, 1 = ramp, 2 = constant, 3 = reserved (treated as 0); latched at frame start.
- i_Ready, in, 1, downstream ready.
- o_Data, out, NUM_CH*OUT_W, output beat; each channel left-justified, low bits zero.
- o_Valid, out, 1, beat valid.
- o_Last, out, 1, final beat of frame; qualified by o_Valid.
- o_Busy, out, 1, high in RUN and DRAIN.
- o_Done, out, 1, frame complete; held until i_ADC_Work is low.
- o_Overflow, out, 1, sticky: at least one beat dropped in the current frame.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, and all counters clear. Reset mid-frame discards any held beat immediately.
- Input stage: i_CMOS_Data is registered once every cycle. Output beat is registered, so a sample reaches o_Data 2 cycles after it is on the pins.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when i_ADC_Work=1.
  - At this transition: latch i_Count, i_Decim and i_Mode; clear the beat counter, decimation counter and o_Overflow.
- IDLE with i_ADC_Work=1 and latched count = 0: go directly to DONE; no beats are produced.
- RUN, beat timing:
  - Decimation counter counts 0..D-1.
  - A beat is due when it equals 0.
  - Beat index n runs from 0 to Count-1.
- RUN, beat content per channel k:
  - Mode 0: registered sample.
  - Mode 1: (n + k) mod 2^DATA_W.
  - Mode 2: CONST_PAT.
  - Each value is shifted left by OUT_W-DATA_W.
- RUN, beat issue:
  - If the output register is empty, or is accepted (o_Valid & i_Ready) in the same cycle: load the beat, set o_Valid, and set o_Last = (n == Count-1).
  - Otherwise: drop the beat and set o_Overflow.
  - n increments in both cases.
- Held beats: while o_Valid=1 and i_Ready=0, o_Data and o_Last are stable.
- Dropped final beat: if beat Count-1 is dropped, o_Last is forced to 1 on the currently held beat, so framing always closes.
- RUN -> DRAIN after beat Count-1 is issued or dropped. DRAIN -> DONE when the output register is empty.
  - If the final beat is accepted in the cycle it is issued, the block passes through DRAIN for 1 cycle.
  - o_Done rises 1 cycle after the last handshake.
- DONE: o_Done=1 and o_Busy=0. DONE -> IDLE when i_ADC_Work=0. o_Done clears on that transition.
- Abort: i_ADC_Work=0 during RUN stops beat generation and moves to DRAIN.
  - The held beat is delivered unchanged; o_Last is not forced.
  - After draining, go to IDLE, not DONE, so o_Done is never asserted.
- o_Overflow stays set through DONE and clears at the next frame start or on reset.
- Counter widths: beat counter is 32 bits, so no wrap within a frame. The ramp value wraps naturally at 2^DATA_W.
- i_Count, i_Decim and i_Mode changes during a frame have no effect.

Test Plan:
- Ramp, NUM_CH=2, Count=5, D=1, i_Ready=1 -> 5 consecutive beats.
  - ch0 = 0,1,2,3,4 <<4; ch1 = 1..5 <<4.
  - o_Last on the 5th beat only; o_Done 1 cycle after the last beat; o_Overflow=0.
- Constant mode, Count=3, D=4 -> beats spaced exactly 4 cycles apart.
  - Each channel = 16'h9290.
  - Release of i_ADC_Work clears o_Done.
- Ramp, Count=6, i_Ready low for 3 cycles covering beats 1-2 -> beat 0 held stable; beat 1 dropped; o_Overflow=1; beat 2 or later resumes with ramp index n.
- Backpressure across the final beat, Count=4 -> held beat carries o_Last=1; o_Done only after it is accepted.
- i_ADC_Work dropped after 2 of 10 beats -> no further beats; no o_Last; o_Done stays 0; FSM returns to IDLE; a new request restarts at n=0.
- Count=0 -> DONE with zero valid beats. Reset asserted mid-RUN -> all outputs 0 on the next cycle.
